// File: rtl/keypad_calc_pkg.sv
// Shared types and constants for the keypad BCD calculator.
package keypad_calc_pkg;

  typedef enum logic [2:0] {
    S_OPA,
    S_OPB,
    S_ADD,
    S_NEG,
    S_SHOW
  } calc_state_t;

  localparam logic [3:0] KEY_ENT = 4'hA;
  localparam logic [3:0] KEY_CLR = 4'hB;

  function automatic logic [3:0] nines(input logic [3:0] d);
    return 4'd9 - d;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single BCD digit adder with carry in/out; inputs are assumed to be valid BCD digits.
module bcd_digit_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] sum;

  always_comb begin
    sum = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    if (sum > 5'd9) begin
      s    = 4'(sum - 5'd10);
      cout = 1'b1;
    end else begin
      s    = sum[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/keypad_bcd_calc.sv
// Two-operand BCD add/subtract calculator fed by a debounced keypad.
// Arithmetic runs one digit per clock through a single shared digit adder.
module keypad_bcd_calc
  import keypad_calc_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    key_valid,
  input  logic [3:0]              key_code,
  input  logic                    mode,
  output logic [4*DIGITS-1:0]     opnd_disp,
  output logic [4*(DIGITS+1)-1:0] result_bcd,
  output logic                    result_neg,
  output logic                    busy,
  output logic                    done,
  output calc_state_t             state_dbg
);

  localparam int OW = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(DIGITS + 1);

  calc_state_t    state;
  logic           key_valid_q;
  logic           press, is_digit, is_ent, is_clr;
  logic [OW-1:0]  opa, opb;
  logic [CW-1:0]  cnt;
  logic [IW-1:0]  idx;
  logic           carry, mode_q;
  logic           last;
  logic [3:0]     add_a, add_b, add_s;
  logic           add_cout;

  // Handshake: a key counts once, on the cycle key_valid rises; key_code is sampled then.
  assign press    = key_valid & ~key_valid_q;
  assign is_digit = press && (key_code <= 4'd9);
  assign is_ent   = press && (key_code == KEY_ENT);
  assign is_clr   = press && (key_code == KEY_CLR);
  assign last     = (idx == IW'(DIGITS - 1));

  assign opnd_disp = (state == S_OPA) ? opa : opb;
  assign state_dbg = state;

  // S_NEG reuses the adder to form the tens complement of the partial result.
  always_comb begin
    add_a = '0;
    add_b = '0;
    if (state == S_NEG) begin
      add_a = nines(result_bcd[{idx, 2'b00} +: 4]);
    end else begin
      add_a = opa[{idx, 2'b00} +: 4];
      add_b = mode_q ? nines(opb[{idx, 2'b00} +: 4]) : opb[{idx, 2'b00} +: 4];
    end
  end

  bcd_digit_add u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry),
    .s    (add_s),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_OPA;
      key_valid_q <= 1'b0;
      opa         <= '0;
      opb         <= '0;
      cnt         <= '0;
      idx         <= '0;
      carry       <= 1'b0;
      mode_q      <= 1'b0;
      result_bcd  <= '0;
      result_neg  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      key_valid_q <= key_valid;
      done        <= 1'b0;
      if (is_clr) begin
        state      <= S_OPA;
        opa        <= '0;
        opb        <= '0;
        cnt        <= '0;
        result_bcd <= '0;
        result_neg <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          S_OPA: begin
            if (is_digit && (cnt < CW'(DIGITS))) begin
              opa <= (opa << 4) | OW'(key_code);
              cnt <= cnt + 1'b1;
            end else if (is_ent) begin
              state <= S_OPB;
              cnt   <= '0;
              opb   <= '0;
            end
          end
          S_OPB: begin
            if (is_digit && (cnt < CW'(DIGITS))) begin
              opb <= (opb << 4) | OW'(key_code);
              cnt <= cnt + 1'b1;
            end else if (is_ent) begin
              state      <= S_ADD;
              mode_q     <= mode;
              carry      <= mode;
              idx        <= '0;
              result_bcd <= '0;
              busy       <= 1'b1;
            end
          end
          S_ADD: begin
            result_bcd[{idx, 2'b00} +: 4] <= add_s;
            carry <= add_cout;
            idx   <= idx + 1'b1;
            if (last) begin
              if (!mode_q || add_cout) begin
                result_bcd[4*DIGITS +: 4] <= {3'b000, add_cout & ~mode_q};
                result_neg <= 1'b0;
                state      <= S_SHOW;
                busy       <= 1'b0;
                done       <= 1'b1;
              end else begin
                state <= S_NEG;
                idx   <= '0;
                carry <= 1'b1;
              end
            end
          end
          S_NEG: begin
            result_bcd[{idx, 2'b00} +: 4] <= add_s;
            carry <= add_cout;
            idx   <= idx + 1'b1;
            if (last) begin
              result_neg <= 1'b1;
              state      <= S_SHOW;
              busy       <= 1'b0;
              done       <= 1'b1;
            end
          end
          S_SHOW: begin
            if (is_digit) begin
              opa        <= OW'(key_code);
              opb        <= '0;
              cnt        <= CW'(1);
              result_bcd <= '0;
              result_neg <= 1'b0;
              state      <= S_OPA;
            end
          end
          default: state <= S_OPA;
        endcase
      end
    end
  end

endmodule
